// File: rtl/udp_multi_channel_rx.sv
// udp_multi_channel_rx
//   Receives Ethernet/IPv4/UDP frames from the MAC receive FIFO. UDP payloads
//   go to NUM_CH channels, selected by destination port. Each channel tracks a
//   16-bit sequence number. ARP requests for my_ip are reported.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   rd_flags_i[1:0]       SOF/EOF of rd_data_i; rd_src_rdy_i/rd_dst_rdy_o handshake
//   my_mac, my_ip         station addresses
//   out_*                 one registered payload stage, valid/ready handshake
//   seq_err, trunc_err    1-cycle error pulses
//   drop_cnt              count of rejected frames
//   arp_req/sha/spa       ARP request pulse and the requester's addresses
//
//   state     | meaning
//   S_IDLE    | waiting for a SOF word (W0)
//   S_HDR     | checking Ethernet/IPv4/UDP header words W1..W9
//   S_SEQ     | W10: sequence number of the selected channel
//   S_PAYLOAD | forwarding payload words to the output stage
//   S_ARP     | checking ARP body words W4..W10
//   S_SKIP    | discarding words up to and including EOF
module udp_multi_channel_rx #(
   parameter int          NUM_CH    = 4,
   parameter logic [15:0] PORT_BASE = 16'd4000,
   parameter int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        rd_flags_i,
   input  logic [31:0]       rd_data_i,
   input  logic              rd_src_rdy_i,
   output logic              rd_dst_rdy_o,
   input  logic [47:0]       my_mac,
   input  logic [31:0]       my_ip,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_sof,
   output logic              out_eof,
   output logic [NUM_CH-1:0] seq_err,
   output logic              trunc_err,
   output logic [15:0]       drop_cnt,
   output logic              arp_req,
   output logic [47:0]       arp_sha,
   output logic [31:0]       arp_spa
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAYLOAD, S_ARP, S_SKIP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic              mac_hi_me_q, mac_hi_me_d, mac_hi_bc_q, mac_hi_bc_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [13:0]       rem_q, rem_d;
   logic              first_q, first_d;
   logic [15:0]       exp_q [NUM_CH];
   logic [15:0]       exp_d [NUM_CH];
   logic [15:0]       sha_hi_q, sha_hi_d;
   logic [31:0]       sha_lo_q, sha_lo_d, spa_q, spa_d;
   logic [31:0]       out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
   logic [CH_W-1:0]   out_ch_q, out_ch_d;
   logic [NUM_CH-1:0] seq_err_q, seq_err_d;
   logic              trunc_q, trunc_d, arp_req_q, arp_req_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [47:0]       arp_sha_q, arp_sha_d;
   logic [31:0]       arp_spa_q, arp_spa_d;

   logic        acc, sof, eof, drop_a, drop_b, hdr_fail, arp_fail;
   logic        mac_lo_me, mac_lo_bc, is_ipv4, is_arp, port_ok, len_ok;
   logic [15:0] port_off, pay_len;
   logic        unused_flags;

   assign unused_flags = ^rd_flags_i[3:2];
   assign sof          = rd_flags_i[0];
   assign eof          = rd_flags_i[1];
   assign rd_dst_rdy_o = (state_q != S_PAYLOAD) || !out_valid_q || out_ready;
   assign acc          = rd_src_rdy_i && rd_dst_rdy_o;

   assign mac_lo_me = (rd_data_i[31:16] == my_mac[15:0]);
   assign mac_lo_bc = (rd_data_i[31:16] == 16'hFFFF);
   assign is_ipv4   = (rd_data_i[31:8] == 24'h08_0045);
   assign is_arp    = (rd_data_i == 32'h0806_0001);
   assign port_off  = rd_data_i[31:16] - PORT_BASE;
   assign pay_len   = rd_data_i[15:0] - 16'd8;
   assign port_ok   = (port_off < 16'(NUM_CH));
   assign len_ok    = (pay_len >= 16'd6) && (pay_len[1:0] == 2'b10);

   // Per-word header checks, keyed by word index; only meaningful in HDR/ARP.
   always_comb begin
      hdr_fail = 1'b0;
      arp_fail = 1'b0;
      case (idx_q)
         4'd1:  hdr_fail = !((mac_hi_me_q && mac_lo_me) || (mac_hi_bc_q && mac_lo_bc));
         // After W1, mac_hi_me_q means the whole MAC matched; broadcast is ARP-only.
         4'd3:  hdr_fail = !((is_ipv4 && mac_hi_me_q) || is_arp);
         4'd5:  hdr_fail = (rd_data_i[7:0] != 8'h11);
         4'd7:  hdr_fail = (rd_data_i[15:0] != my_ip[31:16]);
         4'd8:  hdr_fail = (rd_data_i[31:16] != my_ip[15:0]);
         4'd9:  hdr_fail = !(port_ok && len_ok);
         default: ;
      endcase
      case (idx_q)
         4'd4:  arp_fail = (rd_data_i != 32'h0800_0604);
         4'd5:  arp_fail = (rd_data_i[31:16] != 16'h0001);
         4'd9:  arp_fail = (rd_data_i[15:0] != my_ip[31:16]);
         4'd10: arp_fail = (rd_data_i[31:16] != my_ip[15:0]);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (acc) begin
         if (sof) begin
            state_d = eof ? S_IDLE : S_HDR;
         end else begin
            case (state_q)
               S_HDR: begin
                  if (eof)                          state_d = S_IDLE;
                  else if (hdr_fail)                state_d = S_SKIP;
                  else if (idx_q == 4'd3 && is_arp) state_d = S_ARP;
                  else if (idx_q == 4'd9)           state_d = S_SEQ;
               end
               S_SEQ:     state_d = eof ? S_IDLE : S_PAYLOAD;
               S_PAYLOAD: begin
                  if (eof)                 state_d = S_IDLE;
                  else if (rem_q == 14'd1) state_d = S_SKIP;
               end
               S_ARP: begin
                  if (eof)                                state_d = S_IDLE;
                  else if (arp_fail || idx_q == 4'd10)    state_d = S_SKIP;
               end
               S_SKIP: if (eof) state_d = S_IDLE;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      idx_d       = idx_q;
      mac_hi_me_d = mac_hi_me_q;
      mac_hi_bc_d = mac_hi_bc_q;
      ch_d        = ch_q;
      rem_d       = rem_q;
      first_d     = first_q;
      exp_d       = exp_q;
      sha_hi_d    = sha_hi_q;
      sha_lo_d    = sha_lo_q;
      spa_d       = spa_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;
      arp_sha_d   = arp_sha_q;
      arp_spa_d   = arp_spa_q;
      seq_err_d   = '0;
      trunc_d     = 1'b0;
      arp_req_d   = 1'b0;
      drop_a      = 1'b0;
      drop_b      = 1'b0;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (acc) begin
         if (sof) begin
            idx_d       = 4'd1;
            mac_hi_me_d = (rd_data_i == my_mac[47:16]);
            mac_hi_bc_d = (rd_data_i == 32'hFFFF_FFFF);
            drop_a      = (state_q != S_IDLE);
            drop_b      = eof;
         end else begin
            case (state_q)
               S_HDR: begin
                  idx_d  = idx_q + 4'd1;
                  drop_b = eof || hdr_fail;
                  if (idx_q == 4'd1) mac_hi_me_d = mac_hi_me_q && mac_lo_me;
                  if (idx_q == 4'd9) begin
                     ch_d  = port_off[CH_W-1:0];
                     // P[1:0] == 2'b10 makes (P - 2) / 4 equal to P >> 2.
                     rem_d = pay_len[15:2];
                  end
               end
               S_SEQ: begin
                  if (eof) begin
                     drop_b = 1'b1;
                  end else begin
                     seq_err_d[ch_q] = (rd_data_i[15:0] != exp_q[ch_q]);
                     exp_d[ch_q]     = rd_data_i[15:0] + 16'd1;
                     first_d         = 1'b1;
                  end
               end
               S_PAYLOAD: begin
                  out_data_d  = rd_data_i;
                  out_valid_d = 1'b1;
                  out_ch_d    = ch_q;
                  out_sof_d   = first_q;
                  out_eof_d   = eof || (rem_q == 14'd1);
                  trunc_d     = eof && (rem_q != 14'd1);
                  first_d     = 1'b0;
                  rem_d       = rem_q - 14'd1;
               end
               S_ARP: begin
                  idx_d  = idx_q + 4'd1;
                  drop_b = arp_fail || (eof && idx_q != 4'd10);
                  if (idx_q == 4'd5) sha_hi_d = rd_data_i[15:0];
                  if (idx_q == 4'd6) sha_lo_d = rd_data_i;
                  if (idx_q == 4'd7) spa_d    = rd_data_i;
                  if (idx_q == 4'd10 && !arp_fail) begin
                     arp_sha_d = {sha_hi_q, sha_lo_q};
                     arp_spa_d = spa_q;
                     arp_req_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
      // A restart can drop the interrupted frame and a one-word frame together.
      drop_cnt_d = drop_cnt_q + {15'd0, drop_a} + {15'd0, drop_b};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         mac_hi_me_q <= 1'b0;
         mac_hi_bc_q <= 1'b0;
         ch_q        <= '0;
         rem_q       <= '0;
         first_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) exp_q[i] <= '0;
         sha_hi_q    <= '0;
         sha_lo_q    <= '0;
         spa_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         seq_err_q   <= '0;
         trunc_q     <= 1'b0;
         drop_cnt_q  <= '0;
         arp_req_q   <= 1'b0;
         arp_sha_q   <= '0;
         arp_spa_q   <= '0;
      end else begin
         idx_q       <= idx_d;
         mac_hi_me_q <= mac_hi_me_d;
         mac_hi_bc_q <= mac_hi_bc_d;
         ch_q        <= ch_d;
         rem_q       <= rem_d;
         first_q     <= first_d;
         exp_q       <= exp_d;
         sha_hi_q    <= sha_hi_d;
         sha_lo_q    <= sha_lo_d;
         spa_q       <= spa_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         seq_err_q   <= seq_err_d;
         trunc_q     <= trunc_d;
         drop_cnt_q  <= drop_cnt_d;
         arp_req_q   <= arp_req_d;
         arp_sha_q   <= arp_sha_d;
         arp_spa_q   <= arp_spa_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign seq_err   = seq_err_q;
   assign trunc_err = trunc_q;
   assign drop_cnt  = drop_cnt_q;
   assign arp_req   = arp_req_q;
   assign arp_sha   = arp_sha_q;
   assign arp_spa   = arp_spa_q;

endmodule

// File: tb/tb_udp_multi_channel_rx.sv
// Testbench for udp_multi_channel_rx: directed frames, payload scoreboard,
// pulse counters compared against a small reference model.
module tb_udp_multi_channel_rx;

   localparam logic [47:0] MY_MAC  = 48'h0211_2233_4455;
   localparam logic [31:0] MY_IP   = 32'hC0A8_0164;
   localparam logic [47:0] SRC_MAC = 48'h0A0B_0C0D_0E0F;
   localparam logic [31:0] SRC_IP  = 32'hC0A8_010A;
   localparam logic [47:0] BC_MAC  = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rd_flags_i;
   logic [31:0] rd_data_i;
   logic        rd_src_rdy_i;
   logic        rd_dst_rdy_o;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ch;
   logic        out_sof, out_eof;
   logic [3:0]  seq_err;
   logic        trunc_err;
   logic [15:0] drop_cnt;
   logic        arp_req;
   logic [47:0] arp_sha;
   logic [31:0] arp_spa;

   always #5 clk = ~clk;

   udp_multi_channel_rx #(.NUM_CH(4), .PORT_BASE(16'd4000)) dut (
      .clk(clk), .reset(reset),
      .rd_flags_i(rd_flags_i), .rd_data_i(rd_data_i),
      .rd_src_rdy_i(rd_src_rdy_i), .rd_dst_rdy_o(rd_dst_rdy_o),
      .my_mac(MY_MAC), .my_ip(MY_IP),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_sof(out_sof), .out_eof(out_eof),
      .seq_err(seq_err), .trunc_err(trunc_err), .drop_cnt(drop_cnt),
      .arp_req(arp_req), .arp_sha(arp_sha), .arp_spa(arp_spa)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  ch;
      logic        sof;
      logic        eof;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] frm[$];
   int          checks = 0, errors = 0;
   int          xfer_cnt = 0, exp_xfer = 0, unexpected = 0;
   int          seq_err_cnt [4] = '{0, 0, 0, 0};
   int          exp_seq_err [4] = '{0, 0, 0, 0};
   logic [15:0] model_seq   [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
   int          trunc_cnt = 0, exp_trunc = 0, arp_cnt = 0, exp_arp = 0;
   logic [15:0] exp_drop = 16'd0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) if (seq_err[i]) seq_err_cnt[i]++;
         if (trunc_err) trunc_cnt++;
         if (arp_req) arp_cnt++;
         if (out_valid && out_ready) begin
            xfer_cnt++;
            if (sb.size() == 0) begin
               unexpected++;
            end else begin
               mon_e = sb.pop_front();
               check("out_data", 64'(out_data), 64'(mon_e.d));
               check("out_ch",   64'(out_ch),   64'(mon_e.ch));
               check("out_sof",  64'(out_sof),  64'(mon_e.sof));
               check("out_eof",  64'(out_eof),  64'(mon_e.eof));
            end
         end
      end
   end

   task automatic build_udp(input logic [47:0] dmac, input logic [31:0] w3,
                            input logic [15:0] dport, input logic [15:0] ulen,
                            input logic [15:0] seq, input int npay, input bit good);
      logic [15:0] off;
      logic [31:0] w;
      exp_t        e;
      off = dport - 16'd4000;
      frm.delete();
      frm.push_back(dmac[47:16]);
      frm.push_back({dmac[15:0], SRC_MAC[47:32]});
      frm.push_back(SRC_MAC[31:0]);
      frm.push_back(w3);
      frm.push_back({ulen + 16'd20, 16'h1234});
      frm.push_back({16'h4000, 8'h40, 8'h11});
      frm.push_back({16'h0000, SRC_IP[31:16]});
      frm.push_back({SRC_IP[15:0], MY_IP[31:16]});
      frm.push_back({MY_IP[15:0], 16'd5555});
      frm.push_back({dport, ulen});
      frm.push_back({16'h0000, seq});
      for (int i = 0; i < npay; i++) begin
         w = $urandom;
         frm.push_back(w);
         if (good) begin
            e.d = w; e.ch = off[1:0]; e.sof = (i == 0); e.eof = (i == npay - 1);
            sb.push_back(e);
            exp_xfer++;
         end
      end
      if (good) begin
         if (seq != model_seq[off[1:0]]) exp_seq_err[off[1:0]]++;
         model_seq[off[1:0]] = seq + 16'd1;
      end
   endtask

   task automatic build_arp(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
      frm.delete();
      frm.push_back(32'hFFFF_FFFF);
      frm.push_back({16'hFFFF, sha[47:32]});
      frm.push_back(sha[31:0]);
      frm.push_back(32'h0806_0001);
      frm.push_back(32'h0800_0604);
      frm.push_back({16'h0001, sha[47:32]});
      frm.push_back(sha[31:0]);
      frm.push_back(spa);
      frm.push_back(32'h0000_0000);
      frm.push_back({16'h0000, tpa[31:16]});
      frm.push_back({tpa[15:0], 16'h0000});
      frm.push_back(32'h0);
      frm.push_back(32'h0);
   endtask

   task automatic wait_accept();
      int n;
      n = 0;
      @(negedge clk);
      while (!rd_dst_rdy_o && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) check("accept_timeout", 64'(n), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic drive(input int i);
      logic [3:0] f;
      f = 4'b1100;
      if (i == 0) f[0] = 1'b1;
      if (i == frm.size() - 1) f[1] = 1'b1;
      rd_data_i    = frm[i];
      rd_flags_i   = f;
      rd_src_rdy_i = 1'b1;
   endtask

   task automatic send_frame(input int stall_at);
      for (int i = 0; i < frm.size(); i++) begin
         drive(i);
         if (i == stall_at) begin
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_rdy",   64'(rd_dst_rdy_o), 64'd0);
               check("stall_valid", 64'(out_valid),    64'd1);
               check("stall_data",  64'(out_data),     64'(sb[0].d));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
         wait_accept();
      end
      rd_src_rdy_i = 1'b0;
      rd_flags_i   = 4'b0000;
   endtask

   task automatic post_checks();
      repeat (4) @(posedge clk);
      #1;
      check("xfer_cnt",   64'(xfer_cnt),   64'(exp_xfer));
      check("sb_empty",   64'(sb.size()),  64'd0);
      check("unexpected", 64'(unexpected), 64'd0);
      check("out_valid",  64'(out_valid),  64'd0);
      check("drop_cnt",   64'(drop_cnt),   64'(exp_drop));
      check("trunc_cnt",  64'(trunc_cnt),  64'(exp_trunc));
      check("arp_cnt",    64'(arp_cnt),    64'(exp_arp));
      for (int i = 0; i < 4; i++) check("seq_err_cnt", 64'(seq_err_cnt[i]), 64'(exp_seq_err[i]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      rd_flags_i   = 4'b0000;
      rd_data_i    = 32'h0;
      rd_src_rdy_i = 1'b0;
      out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_dst_rdy",   64'(rd_dst_rdy_o), 64'd1);
      check("rst_out_valid", 64'(out_valid),    64'd0);
      check("rst_out_data",  64'(out_data),     64'd0);
      check("rst_drop_cnt",  64'(drop_cnt),     64'd0);
      check("rst_seq_err",   64'(seq_err),      64'd0);
      check("rst_trunc",     64'(trunc_err),    64'd0);
      check("rst_arp_req",   64'(arp_req),      64'd0);
      check("rst_arp_sha",   64'(arp_sha),      64'd0);

      // Basic frame on channel 2, then sequence error and recovery.
      build_udp(MY_MAC, 32'h0800_4500, 16'd4002, 16'd26, 16'd0, 4, 1'b1);
      send_frame(-1); post_checks();
      build_udp(MY_MAC, 32'h0800_4500, 16'd4002, 16'd26, 16'd5, 4, 1'b1);
      send_frame(-1); post_checks();
      build_udp(MY_MAC, 32'h0800_45AA, 16'd4002, 16'd26, 16'd6, 4, 1'b1);
      send_frame(-1); post_checks();

      // Minimum payload: P = 6 gives one word carrying both sof and eof.
      build_udp(MY_MAC, 32'h0800_4500, 16'd4000, 16'd14, 16'd0, 1, 1'b1);
      send_frame(-1); post_checks();

      // Output stall in the middle of a 6-word payload on channel 1.
      build_udp(MY_MAC, 32'h0800_4500, 16'd4001, 16'd34, 16'd0, 6, 1'b1);
      send_frame(13); post_checks();

      // Rejected frames.
      build_udp({MY_MAC[47:16], 16'h9999}, 32'h0800_4500, 16'd4002, 16'd26, 16'd7, 4, 1'b0);
      exp_drop++; send_frame(-1); post_checks();
      build_udp(MY_MAC, 32'h86DD_6000, 16'd4002, 16'd26, 16'd7, 4, 1'b0);
      exp_drop++; send_frame(-1); post_checks();
      build_udp(MY_MAC, 32'h0800_4500, 16'd4004, 16'd26, 16'd0, 4, 1'b0);
      exp_drop++; send_frame(-1); post_checks();
      build_udp(MY_MAC, 32'h0800_4500, 16'd4002, 16'd25, 16'd7, 4, 1'b0);
      exp_drop++; send_frame(-1); post_checks();
      build_udp(BC_MAC, 32'h0800_4500, 16'd4002, 16'd26, 16'd7, 4, 1'b0);
      exp_drop++; send_frame(-1); post_checks();

      // Truncated payload: EOF on the 2nd of 4 words, then a normal frame.
      build_udp(MY_MAC, 32'h0800_4500, 16'd4003, 16'd26, 16'd0, 2, 1'b1);
      exp_trunc++; send_frame(-1); post_checks();
      build_udp(MY_MAC, 32'h0800_4500, 16'd4003, 16'd26, 16'd1, 4, 1'b1);
      send_frame(-1); post_checks();

      // ARP request for us, then one for another address.
      build_arp(48'h0200_0000_0001, 32'hC0A8_010A, MY_IP);
      exp_arp++; send_frame(-1); post_checks();
      check("arp_sha", 64'(arp_sha), 64'h0200_0000_0001);
      check("arp_spa", 64'(arp_spa), 64'hC0A8_010A);
      build_arp(48'h0200_0000_0077, 32'hC0A8_0177, MY_IP + 32'd1);
      exp_drop++; send_frame(-1); post_checks();
      check("arp_sha_hold", 64'(arp_sha), 64'h0200_0000_0001);
      check("arp_spa_hold", 64'(arp_spa), 64'hC0A8_010A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_multi_channel_rx.md
Name: udp_multi_channel_rx

Overview:
- Next-generation Ethernet/IPv4/UDP receiver between the MAC receive FIFO (32-bit words, SOF/EOF flags) and the DAC/CPU/other sinks.
- Demultiplexes UDP payloads to NUM_CH channels by destination port and tracks a 16-bit sequence number per channel.
- Applies backpressure from a single registered output stage.
- Detects ARP requests for my_ip and reports the requester's addresses.

Parameters:
- NUM_CH, 4: number of payload channels, 1..16.
- PORT_BASE, 16'd4000: UDP port of channel 0; channel = dst_port - PORT_BASE.
- CH_W, derived max(1, clog2(NUM_CH)): width of out_ch.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_flags_i  in  4  [0]=SOF, [1]=EOF; [3:2] ignored
- rd_data_i  in  32  frame word, big-endian, first byte in [31:24]
- rd_src_rdy_i  in  1  input word valid
- rd_dst_rdy_o  out  1  input word accepted when rd_src_rdy_i && rd_dst_rdy_o
- my_mac  in  48  station MAC
- my_ip  in  32  station IP
- out_data  out  32  payload word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts; transfer = out_valid && out_ready
- out_ch  out  CH_W  channel of out_data
- out_sof  out  1  first payload word of a frame
- out_eof  out  1  last payload word of a frame
- seq_err  out  NUM_CH  1-cycle pulse: sequence mismatch on that channel
- trunc_err  out  1  1-cycle pulse: EOF before the UDP length was exhausted
- drop_cnt  out  16  frames rejected, wraps at 0xFFFF->0
- arp_req  out  1  1-cycle pulse: valid ARP request for my_ip
- arp_sha  out  48  sender MAC of the last ARP request
- arp_spa  out  32  sender IP of the last ARP request

Behaviour:
- Reset: state IDLE; all outputs 0; expected sequence of every channel = 0.
- Reset mid-frame: words are ignored until the next SOF.
- Word indices are counted from the SOF word (W0). Only accepted words advance the state.
- rd_dst_rdy_o = 1 in all states except PAYLOAD, where it equals (!out_valid || out_ready).
- Output stage: out_* hold their value while out_valid && !out_ready; out_valid clears after a transfer with no new word.
- States: IDLE, HDR, SEQ, PAYLOAD, ARP, SKIP.
- IDLE: wait for an accepted SOF word, then go to HDR.
- An accepted SOF in any non-IDLE state restarts parsing at W0. The interrupted frame counts as a drop; an open payload is not closed.
- HDR checks:
  - W0–W1: dst MAC must equal my_mac or FF:FF:FF:FF:FF:FF.
  - W3: 0x0800_45xx selects IPv4/UDP; 0x0806_0001 selects ARP; anything else is rejected.
  - W5[7:0] must be 0x11. Broadcast MAC is accepted for ARP only.
  - dst IP (W7[15:0], W8[31:16]) must equal my_ip.
  - W9: dst_port - PORT_BASE must be < NUM_CH.
  - Payload P = udp_len - 8 (16-bit). Require P >= 6 and P[1:0] == 2'b10.
- Any failed check: drop_cnt += 1, then go to SKIP. An EOF on the failing word goes to IDLE instead.
- An EOF anywhere in HDR: drop_cnt += 1, go to IDLE.
- SEQ (W10): seq = W10[15:0].
  - If seq != exp[ch], seq_err[ch] pulses the next cycle.
  - exp[ch] <= seq + 1 (mod 2^16) in either case.
  - Remaining data words = (P - 2) / 4.
- PAYLOAD: each accepted word is loaded into out_data with out_ch = ch. out_sof = 1 on the first word only.
  - Last counted word: out_eof = 1. Go to IDLE if the word carries EOF, else SKIP.
  - EOF before the count is exhausted: that word gets out_eof = 1; trunc_err pulses; go to IDLE.
- ARP: require W4 == 0x0800_0604, W5[31:16] == 0x0001, and tpa (W9[15:0], W10[31:16]) == my_ip.
  - sha = W5[15:0], W6; spa = W7.
  - On W10: latch arp_sha/arp_spa and pulse arp_req. Go to IDLE if the word carries EOF, else SKIP.
  - A failed ARP check is a drop.
- SKIP: discard accepted words until one carries EOF, then go to IDLE.
- Latency: an accepted payload word appears on out_data the next cycle.

Test Plan:
- NUM_CH=4, PORT_BASE=4000, dst_port 4002, udp_len 26 (P=18), seq 0 -> 4 words on out_ch=2 with sof/eof on first/last; no seq_err; exp[2]=1.
- Same channel, seq 0 then seq 5 -> seq_err[2] pulses once on the second frame; exp[2]=6; a third frame with seq 6 gives no error.
- Payload with out_ready held low for 3 cycles mid-frame -> rd_dst_rdy_o low during the stall, out_data stable, no word lost or duplicated.
- Frames with a wrong MAC, ethertype 0x86DD, dst_port 4004, and udp_len 25 -> no out_valid; drop_cnt increments 0->4.
- EOF on the 2nd of 4 payload words -> out_eof on that word, trunc_err pulse, next frame parsed correctly.
- Broadcast ARP request, tpa = my_ip, sha 02:00:00:00:00:01, spa 192.168.1.10 -> arp_req pulses once with those values; tpa != my_ip -> no pulse, drop_cnt += 1.
